// File: rtl/lpif_tx_scheduler.sv
// LPIF transmit scheduler: arbitrates TLP and DLLP sources at packet boundaries and
// drives one registered, framed LPIF beat per accepted transfer toward the PHY.
module lpif_tx_scheduler #(
  parameter int LPIF_BYTES   = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    linkUp,
  input  logic                    pl_trdy,
  input  logic                    tlp_valid,
  input  logic [8*LPIF_BYTES-1:0] tlp_data,
  input  logic [LPIF_BYTES-1:0]   tlp_bvalid,
  input  logic                    tlp_last,
  output logic                    tlp_ready,
  input  logic                    dllp_valid,
  input  logic [47:0]             dllp_data,
  output logic                    dllp_ready,
  output logic                    lp_irdy,
  output logic [8*LPIF_BYTES-1:0] lp_data,
  output logic [LPIF_BYTES-1:0]   lp_valid,
  output logic [LPIF_BYTES-1:0]   lp_tlpstart,
  output logic [LPIF_BYTES-1:0]   lp_tlpend,
  output logic [LPIF_BYTES-1:0]   lp_dlpstart,
  output logic [LPIF_BYTES-1:0]   lp_dlpend
);

  localparam int DW = 8 * LPIF_BYTES;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]         STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [LPIF_BYTES-1:0] DLLP_MASK  = LPIF_BYTES'(6'h3F);
  localparam logic [LPIF_BYTES-1:0] DLLP_START = LPIF_BYTES'(1);
  localparam logic [LPIF_BYTES-1:0] DLLP_END   = LPIF_BYTES'(6'h20);

  typedef enum logic {IDLE, TLP_BODY} state_t;

  state_t                  state_q, state_d;
  logic [SW-1:0]           starve_q, starve_d;
  logic                    lp_irdy_q, lp_irdy_d;
  logic [DW-1:0]           lp_data_q, lp_data_d;
  logic [LPIF_BYTES-1:0]   lp_valid_q, lp_valid_d;
  logic [LPIF_BYTES-1:0]   tlpstart_q, tlpstart_d;
  logic [LPIF_BYTES-1:0]   tlpend_q, tlpend_d;
  logic [LPIF_BYTES-1:0]   dlpstart_q, dlpstart_d;
  logic [LPIF_BYTES-1:0]   dlpend_q, dlpend_d;

  logic                    slot_free;
  logic                    can_grant;
  logic                    dllp_go;
  logic                    tlp_go;
  logic [LPIF_BYTES-1:0]   end_onehot;

  // End marker sits on the highest valid byte of the final beat.
  genvar gi;
  generate
    for (gi = 0; gi < LPIF_BYTES; gi++) begin : g_end
      if (gi == LPIF_BYTES - 1) begin : g_top
        assign end_onehot[gi] = tlp_bvalid[gi];
      end else begin : g_mid
        assign end_onehot[gi] = tlp_bvalid[gi] & ~(|tlp_bvalid[LPIF_BYTES-1:gi+1]);
      end
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    lp_irdy_d  = lp_irdy_q;
    lp_data_d  = lp_data_q;
    lp_valid_d = lp_valid_q;
    tlpstart_d = tlpstart_q;
    tlpend_d   = tlpend_q;
    dlpstart_d = dlpstart_q;
    dlpend_d   = dlpend_q;
    tlp_ready  = 1'b0;
    dllp_ready = 1'b0;

    slot_free = !lp_irdy_q || pl_trdy;
    can_grant = !reset && linkUp && slot_free;

    case (state_q)
      IDLE: begin
        if (can_grant) begin
          if (dllp_valid && (!tlp_valid || starve_q < STARVE_MAX)) begin
            dllp_ready = 1'b1;
          end else if (tlp_valid) begin
            tlp_ready = 1'b1;
          end
        end
      end
      TLP_BODY: tlp_ready = can_grant;
      default: state_d = IDLE;
    endcase

    dllp_go = dllp_valid && dllp_ready;
    tlp_go  = tlp_valid && tlp_ready;

    if (slot_free) begin
      lp_irdy_d = dllp_go || tlp_go;
    end

    if (dllp_go) begin
      lp_data_d  = DW'(dllp_data);
      lp_valid_d = DLLP_MASK;
      tlpstart_d = '0;
      tlpend_d   = '0;
      dlpstart_d = DLLP_START;
      dlpend_d   = DLLP_END;
      if (tlp_valid) begin
        starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);
      end else begin
        starve_d = '0;
      end
    end else if (tlp_go) begin
      lp_data_d  = tlp_data;
      lp_valid_d = tlp_bvalid;
      tlpstart_d = (state_q == IDLE) ? DLLP_START : '0;
      tlpend_d   = tlp_last ? end_onehot : '0;
      dlpstart_d = '0;
      dlpend_d   = '0;
      starve_d   = '0;
      state_d    = tlp_last ? IDLE : TLP_BODY;
    end

    // Losing the link abandons any partial TLP; the link layer replays it.
    if (!linkUp) begin
      lp_irdy_d = 1'b0;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      lp_irdy_q  <= 1'b0;
      lp_data_q  <= '0;
      lp_valid_q <= '0;
      tlpstart_q <= '0;
      tlpend_q   <= '0;
      dlpstart_q <= '0;
      dlpend_q   <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      lp_irdy_q  <= lp_irdy_d;
      lp_data_q  <= lp_data_d;
      lp_valid_q <= lp_valid_d;
      tlpstart_q <= tlpstart_d;
      tlpend_q   <= tlpend_d;
      dlpstart_q <= dlpstart_d;
      dlpend_q   <= dlpend_d;
    end
  end

  assign lp_irdy     = lp_irdy_q;
  assign lp_data     = lp_data_q;
  assign lp_valid    = lp_valid_q;
  assign lp_tlpstart = tlpstart_q;
  assign lp_tlpend   = tlpend_q;
  assign lp_dlpstart = dlpstart_q;
  assign lp_dlpend   = dlpend_q;

endmodule
